// File: rtl/tmrx_dummy_pkg.sv
// Shared constants and the stage record for the TMRX dummy pipeline.
// Optional parity tracking is enabled with TMRX_DUMMY_PARITY_EN.
package tmrx_dummy_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_DEPTH = 3;
    localparam int unsigned DEFAULT_CNT_W = 8;

    typedef struct packed {
        logic                     valid;
        logic [DEFAULT_WIDTH-1:0] data;
        logic                     parity;
    } stage_t;

endpackage

// File: rtl/tmrx_dummy_core.sv
// Feedback core: AND/XOR state register plus OR/XOR stage-0 output register.
// With TMRX_DUMMY_PARITY_EN an even-parity bit of the stage-0 value is kept alongside.
module tmrx_dummy_core
    import tmrx_dummy_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             acc_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] y_o,
`ifdef TMRX_DUMMY_PARITY_EN
    output logic             p_o,
`endif
    output logic             err_o
);

    logic [WIDTH-1:0] core_q, core_d;
    logic [WIDTH-1:0] s0_q, s0_d;

    // Both updates use the pre-edge core_q and s0_q.
    always_comb begin
        core_d = core_q;
        s0_d   = s0_q;
        if (clr_i) begin
            core_d = '0;
            s0_d   = '0;
        end else if (acc_i) begin
            core_d = (a_i & s0_q) ^ core_q;
            s0_d   = (core_q | a_i) ^ b_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            core_q <= '0;
            s0_q   <= '0;
        end else begin
            core_q <= core_d;
            s0_q   <= s0_d;
        end
    end

`ifdef TMRX_DUMMY_PARITY_EN
    logic p_q, p_d;

    always_comb begin
        p_d = p_q;
        if (clr_i) begin
            p_d = 1'b0;
        end else if (acc_i) begin
            p_d = ^((core_q | a_i) ^ b_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            p_q <= 1'b0;
        end else begin
            p_q <= p_d;
        end
    end

    assign p_o = p_q;
`endif

    assign y_o   = s0_q;
    assign err_o = 1'b0;

endmodule

// File: rtl/tmrx_dummy_pipe.sv
// WIDTH-bit feedback core feeding a DEPTH-stage valid/ready pipeline with stall, clear and handoff counter.
// Define TMRX_DUMMY_PARITY_EN to add parity_o and per-stage parity bits.
module tmrx_dummy_pipe
    import tmrx_dummy_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] in0_i,
    input  logic [WIDTH-1:0] in1_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [WIDTH-1:0] out_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [CNT_W-1:0] cnt_o,
`ifdef TMRX_DUMMY_PARITY_EN
    output logic             parity_o,
`endif
    output logic             err_o
);

    logic             en;
    logic             acc;
    logic [WIDTH-1:0] core_y;
    logic [DEPTH-1:0] valid_q, valid_d, vshift;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef TMRX_DUMMY_PARITY_EN
    logic             core_p;
`endif

    assign en      = !valid_q[DEPTH-1] || ready_i;
    assign ready_o = en && !clr_i;
    assign acc     = valid_i && ready_o;

    tmrx_dummy_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (clr_i),
        .acc_i  (acc),
        .a_i    (in0_i),
        .b_i    (in1_i),
        .y_o    (core_y),
`ifdef TMRX_DUMMY_PARITY_EN
        .p_o    (core_p),
`endif
        .err_o  (err_o)
    );

    if (DEPTH > 1) begin : g_vshift
        assign vshift = {valid_q[DEPTH-2:0], acc};
    end else begin : g_vone
        assign vshift = acc;
    end

    // Valid bits and handoff counter; clear wins over shift and count.
    always_comb begin
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (clr_i) begin
            valid_d = '0;
            cnt_d   = '0;
        end else begin
            if (en) begin
                valid_d = vshift;
            end
            if (valid_q[DEPTH-1] && ready_i) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    // Stages 1..DEPTH-1 only move when the pipeline is not stalled.
    if (DEPTH > 1) begin : g_pipe
        logic [DEPTH-2:0][WIDTH-1:0] sdata_q;
        logic [DEPTH-1:0][WIDTH-1:0] chain_w;

        assign chain_w = {sdata_q, core_y};

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                sdata_q <= '0;
            end else if (en) begin
                sdata_q <= chain_w[DEPTH-2:0];
            end
        end

        assign out_o = chain_w[DEPTH-1];

`ifdef TMRX_DUMMY_PARITY_EN
        logic [DEPTH-2:0] spar_q;
        logic [DEPTH-1:0] pchain_w;

        assign pchain_w = {spar_q, core_p};

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                spar_q <= '0;
            end else if (en) begin
                spar_q <= pchain_w[DEPTH-2:0];
            end
        end

        assign parity_o = pchain_w[DEPTH-1] ^ (^chain_w[DEPTH-1]);
`endif
    end else begin : g_single
        assign out_o = core_y;
`ifdef TMRX_DUMMY_PARITY_EN
        assign parity_o = core_p ^ (^core_y);
`endif
    end

    assign valid_o = valid_q[DEPTH-1];
    assign cnt_o   = cnt_q;

endmodule

// File: doc/tmrx_dummy_pipe.md
Name: tmrx_dummy_pipe

Overview:
- Parametrised successor of the TMRX single-bit feedback test design.
- WIDTH-bit feedback core (AND/XOR state register plus OR/XOR output register) feeds a DEPTH-stage valid/ready pipeline with global stall, synchronous clear and a handoff counter.
- Exercises the TMR pass on multi-bit registers, hierarchy, stall logic and a counter.
- Carries a tmrx_error_sink port that the TMR pass connects.

Parameters:
- WIDTH, 8, data width of in0_i/in1_i/out_o and of internal state.
- DEPTH, 3, pipeline stages including the core output register; legal range >= 1.
- CNT_W, 8, width of the handoff counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- clr_i  in  1  synchronous clear.
- in0_i  in  WIDTH  operand a.
- in1_i  in  WIDTH  operand b.
- valid_i  in  1  input valid.
- ready_o  out  1  input ready.
- out_o  out  WIDTH  last-stage data.
- valid_o  out  1  last-stage valid.
- ready_i  in  1  downstream ready.
- cnt_o  out  CNT_W  completed output handoffs, wrapping.
- err_o  out  1  attribute tmrx_error_sink; RTL drives constant 0, the TMR pass rewires it to voter mismatch.

Behaviour:
- Reset (rst_ni low, asynchronous): core_q, all stage data and valid bits, and cnt_o clear to 0. err_o = 0. ready_o = 1 once reset is released and clr_i is low.
- Stall enable: en = !valid_q[DEPTH-1] || ready_i. ready_o = en && !clr_i. Accept = valid_i && ready_o.
- Core update on accept, evaluated with the pre-edge values of core_q and stage-0 data s0_q:
  - core_q <= (in0_i & s0_q) ^ core_q
  - s0_q <= (core_q | in0_i) ^ in1_i
- Without accept, core_q and s0_q hold.
- When en is high:
  - valid_q[0] <= accept.
  - Stages 1..DEPTH-1 shift data and valid forward.
- When en is low: all stages hold. No data is lost or duplicated.
- Outputs: out_o = data of stage DEPTH-1; valid_o = valid_q[DEPTH-1]. Data is don't-care while valid is low, but the bench checks it only when valid_o is high.
- Latency: with no stall, valid_o rises after the DEPTH-th rising edge, counting the accepting edge as edge 1. Throughput is 1 per cycle.
- Counter: cnt_o increments on valid_o && ready_i. It wraps from 2^CNT_W-1 to 0.
- clr_i (synchronous, priority over everything except reset):
  - Next edge clears core_q, s0_q, all valid bits and cnt_o.
  - An input presented in the same cycle is not accepted, since ready_o is low.
  - An output handshake in the same cycle completes on the bus, but cnt_o still clears.
- Reset mid-stream drops all in-flight data immediately.

Optional Feature:
- Macro: TMRX_DUMMY_PARITY_EN.
- When defined:
  - Adds output parity_o (1 bit).
  - An even-parity bit of the new s0_q value is computed at accept and travels with the data through every stage.
  - parity_o = ^ of the carried bit and out_o. It is 0 for uncorrupted data and is reset to 0.
- When undefined: port and parity registers are absent; behaviour is otherwise identical.

Decomposition:
- Package tmrx_dummy_pkg:
  - Default constants DEFAULT_WIDTH = 8, DEFAULT_DEPTH = 3, DEFAULT_CNT_W = 8.
  - Typedef for a pipeline stage record {valid, data, parity}.
- One sub-module, tmrx_dummy_core:
  - Holds core_q and s0_q, with ports clk_i, rst_ni, clr_i, acc_i, a_i, b_i, y_o.
  - Gives the TMR pass a hierarchical boundary, and carries its own tmrx_error_sink err_o port, also driven 0.

Test Plan:
1. Reset check: assert rst_ni low mid-cycle with data in flight -> out_o, valid_o, cnt_o, err_o read 0 immediately; ready_o = 1 after release.
2. Stream (WIDTH=8, DEPTH=3, ready_i=1): accept (F0,0F), then (0F,00), then (00,00) on consecutive cycles -> out_o = FF, 0F, 0F on consecutive cycles; first valid_o after the 3rd edge; cnt_o = 3.
3. Backpressure: 3 items in flight with ready_i = 0 -> ready_o low once valid_o is high; out_o holds FF for 5 cycles. Release ready_i -> FF, 0F, 0F delivered in order, none lost.
4. Clear collision: clr_i high together with valid_i and in0 = AA -> item not accepted; next cycle valid_o = 0, cnt_o = 0, core state 0; next accept of (F0,0F) yields FF.
5. Counter wrap with CNT_W = 4: 17 handoffs -> cnt_o reads F after 15, 0 after 16, 1 after 17.
6. With TMRX_DUMMY_PARITY_EN defined: parity_o = 0 for every valid output in scenario 2; a forced bit flip on stage-1 data -> parity_o = 1 when that item reaches out_o.
